// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared parity modes, receiver state encoding and parity helper
package uart_defs;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   localparam int MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_t;

   // Callers zero-extend narrower words; the extra zeros do not change the XOR.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0] mode);
      logic p;
      p = ^data;
      if (mode == PAR_ODD) p = ~p;
      return p;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with extra-MSB pointers
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_hold;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
   end

   // r_hold keeps the last head visible once the FIFO drains.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_hold   <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         if (!o_empty)  r_hold   <= r_mem[r_rd_ptr[AW-1:0]];
      end
   end

   assign o_head = o_empty ? r_hold : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - parametrised UART receiver with majority-vote sampling
// and a show-ahead receive FIFO with overrun reporting.
module uart_rx_fifo
   import uart_defs::*;
#(
   parameter int CLKS_PER_BIT = 32,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 1,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 valid,
   input  logic                 ready,
   output logic                 overrun,
   output logic                 busy
);

   localparam int         MID      = CLKS_PER_BIT / 2;
   localparam int         CW       = $clog2(CLKS_PER_BIT);
   localparam int         WW       = DATA_BITS + 2;
   localparam logic [1:0] PAR_MODE = 2'(PARITY);

   logic                 r_sync1, r_rxs, r_rxs_d;
   rx_state_t            r_state, w_state_nx;
   logic [CW-1:0]        r_cnt, w_cnt_nx;
   logic [3:0]           r_bit_idx, w_bit_idx_nx;
   logic [DATA_BITS-1:0] r_shift, w_shift_nx;
   logic                 r_par_err, w_par_err_nx;
   logic                 r_frm_err, w_frm_err_nx;
   logic                 r_overrun;
   logic                 w_fall, w_sample, w_vote, w_push, w_pop;
   logic                 w_fifo_empty, w_fifo_full;
   logic [WW-1:0]        w_push_word, w_head;

   assign w_fall   = r_rxs_d && !r_rxs;
   assign w_sample = (r_cnt == CW'(MID));
   // r_sync1 is rxs one cycle ahead, centring the vote window on the sample point.
   assign w_vote   = (r_rxs_d & r_rxs) | (r_rxs & r_sync1) | (r_rxs_d & r_sync1);

   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = (r_cnt == CW'(CLKS_PER_BIT-1)) ? '0 : r_cnt + CW'(1);
      w_bit_idx_nx = r_bit_idx;
      w_shift_nx   = r_shift;
      w_par_err_nx = r_par_err;
      w_frm_err_nx = r_frm_err;
      w_push       = 1'b0;
      w_push_word  = '0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nx = w_fall ? CW'(1) : '0;
            if (w_fall) begin
               w_state_nx   = ST_START;
               w_par_err_nx = 1'b0;
               w_frm_err_nx = 1'b0;
            end
         end
         ST_START: begin
            if (w_sample) begin
               w_bit_idx_nx = '0;
               w_state_nx   = w_vote ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_sample) begin
               w_shift_nx = {w_vote, r_shift[DATA_BITS-1:1]};
               if (r_bit_idx == 4'(DATA_BITS-1)) begin
                  w_bit_idx_nx = '0;
                  w_state_nx   = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
               end else begin
                  w_bit_idx_nx = r_bit_idx + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (w_sample) begin
               w_par_err_nx = w_vote != calc_parity(MAX_DATA_BITS'(r_shift), PAR_MODE);
               w_state_nx   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_sample) begin
               if (!w_vote) w_frm_err_nx = 1'b1;
               if (r_bit_idx == 4'(STOP_BITS-1)) begin
                  w_push     = 1'b1;
                  w_state_nx = w_vote ? ST_IDLE : ST_WAIT_HIGH;
               end else begin
                  w_bit_idx_nx = r_bit_idx + 4'd1;
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (r_rxs) w_state_nx = ST_IDLE;
         end
         default: w_state_nx = ST_IDLE;
      endcase
      w_push_word = {w_frm_err_nx, r_par_err, r_shift};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1   <= 1'b1;
         r_rxs     <= 1'b1;
         r_rxs_d   <= 1'b1;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         r_sync1   <= rx;
         r_rxs     <= r_sync1;
         r_rxs_d   <= r_rxs;
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_bit_idx <= w_bit_idx_nx;
         r_shift   <= w_shift_nx;
         r_par_err <= w_par_err_nx;
         r_frm_err <= w_frm_err_nx;
      end
   end

   assign w_pop = valid && ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                        r_overrun <= 1'b0;
      else if (w_pop)                  r_overrun <= 1'b0;
      else if (w_push && w_fifo_full)  r_overrun <= 1'b1;
   end

   sync_fifo #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_push_word),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_empty     (w_fifo_empty),
      .o_full      (w_fifo_full)
   );

   assign {frame_err, parity_err, data_out} = w_head;
   assign valid   = !w_fifo_empty;
   assign overrun = r_overrun;
   assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench: default-format receiver (A) and
// odd-parity two-stop-bit receiver (B).
module tb_uart_rx_fifo;

   localparam int CPB = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] a_data, b_data;
   logic       a_perr, a_ferr, a_valid, a_ovr, a_busy;
   logic       b_perr, b_ferr, b_valid, b_ovr, b_busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .data_out(a_data), .parity_err(a_perr),
      .frame_err(a_ferr), .valid(a_valid), .ready(ready), .overrun(a_ovr), .busy(a_busy));

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .data_out(b_data), .parity_err(b_perr),
      .frame_err(b_ferr), .valid(b_valid), .ready(ready), .overrun(b_ovr), .busy(b_busy));

   typedef struct {
      logic       sel;
      logic [7:0] data;
      logic       bad_par;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
      int         exp_lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic sel, input logic val, input int ncyc);
      if (sel) rx_b = val;
      else     rx_a = val;
      repeat (ncyc) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic sel, input logic [7:0] d, input logic bad_par,
                             input logic stop_val);
      logic pbit;
      pbit = (sel ? ~(^d) : ^d) ^ bad_par;
      drive(sel, 1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(sel, d[i], CPB);
      drive(sel, pbit, CPB);
      drive(sel, stop_val, CPB);
      if (sel) drive(sel, stop_val, CPB);
   endtask

   task automatic expect_word(input logic sel, input logic [7:0] d, input logic p,
                              input logic f, input int lat, input string nm);
      int n_seen;
      n_seen = 0;
      for (int n = 1; n <= 500; n++) begin
         @(posedge clk); #1;
         if ((sel ? b_valid : a_valid) == 1'b1) begin
            n_seen = n;
            break;
         end
      end
      chk({nm, "_latency"}, n_seen, lat);
      chk({nm, "_data"}, sel ? b_data : a_data, d);
      chk({nm, "_perr"}, sel ? b_perr : a_perr, p);
      chk({nm, "_ferr"}, sel ? b_ferr : a_ferr, f);
      @(posedge clk); #1;
      chk({nm, "_popped"}, sel ? b_valid : a_valid, 1'b0);
   endtask

   vec_t vecs[7];

   initial begin
      #400_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ovr_exp[4];
      int         extra, seen_busy, seen_valid;

      vecs[0] = '{1'b0, 8'h35, 1'b0, 8'h35, 1'b0, 1'b0, 339};
      vecs[1] = '{1'b0, 8'h4A, 1'b1, 8'h4A, 1'b1, 1'b0, 339};
      vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 339};
      vecs[3] = '{1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 339};
      vecs[4] = '{1'b1, 8'h4A, 1'b0, 8'h4A, 1'b0, 1'b0, 371};
      vecs[5] = '{1'b1, 8'h4A, 1'b1, 8'h4A, 1'b1, 1'b0, 371};
      vecs[6] = '{1'b1, 8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0, 371};
      ovr_exp = '{8'h21, 8'h66, 8'h7E, 8'h87};

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", a_valid, 1'b0);
      chk("rst_data", a_data, 8'h00);
      chk("rst_flags", {a_perr, a_ferr, a_ovr, a_busy}, 4'b0000);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_valid", {a_valid, b_valid, a_busy, b_busy}, 4'b0000);

      for (int i = 0; i < 7; i++) begin
         fork
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].bad_par, 1'b1);
            expect_word(vecs[i].sel, vecs[i].exp_data, vecs[i].exp_perr,
                        vecs[i].exp_ferr, vecs[i].exp_lat, $sformatf("vec%0d", i));
         join
      end

      // stop bit held low, line stays low three more bit times
      extra = 0;
      fork
         begin
            send_frame(1'b0, 8'h5D, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 3*CPB);
            drive(1'b0, 1'b1, 2*CPB);
         end
         begin
            expect_word(1'b0, 8'h5D, 1'b0, 1'b1, 339, "brk");
            for (int n = 0; n < 160; n++) begin
               @(posedge clk); #1;
               if (a_valid) extra++;
            end
         end
      join
      chk("brk_no_second", extra, 0);
      fork
         send_frame(1'b0, 8'h61, 1'b0, 1'b1);
         expect_word(1'b0, 8'h61, 1'b0, 1'b0, 339, "after_brk");
      join

      // 10-cycle glitch
      seen_busy = 0;
      seen_valid = 0;
      rx_a = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (n == 10) rx_a = 1'b1;
         if (a_busy) seen_busy = 1;
         if (a_valid) seen_valid = 1;
         if (n == 3)  chk("glitch_busy_rise", a_busy, 1'b1);
         if (n == 18) chk("glitch_busy_held", a_busy, 1'b1);
         if (n == 19) chk("glitch_busy_fall", a_busy, 1'b0);
      end
      chk("glitch_busy_seen", seen_busy, 1);
      chk("glitch_no_push", seen_valid, 0);

      // overrun: five back-to-back frames into a four-word FIFO
      ready = 1'b0;
      send_frame(1'b0, 8'h21, 1'b0, 1'b1);
      send_frame(1'b0, 8'h66, 1'b0, 1'b1);
      send_frame(1'b0, 8'h7E, 1'b0, 1'b1);
      send_frame(1'b0, 8'h87, 1'b0, 1'b1);
      chk("ovr_not_yet", {a_valid, a_ovr}, 2'b10);
      send_frame(1'b0, 8'h35, 1'b0, 1'b1);
      chk("ovr_set", a_ovr, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovr_pop%0d_valid", i), a_valid, 1'b1);
         chk($sformatf("ovr_pop%0d_data", i), a_data, ovr_exp[i]);
         ready = 1'b1;
         @(posedge clk); #1;
         ready = 1'b0;
         if (i == 0) chk("ovr_cleared", a_ovr, 1'b0);
      end
      chk("ovr_drained", a_valid, 1'b0);
      chk("ovr_hold_data", a_data, 8'h87);

      // reset during data bit 3
      send_frame(1'b0, 8'h35, 1'b1, 1'b1);
      chk("pre_rst_word", {a_valid, a_perr, a_data}, {2'b11, 8'h35});
      drive(1'b0, 1'b0, CPB);
      drive(1'b0, 1'b1, 3*CPB);
      rx_a = 1'b0;
      repeat (16) @(posedge clk);
      chk("pre_rst_busy", a_busy, 1'b1);
      #3 rst = 1'b0;
      #1;
      chk("async_rst_valid", a_valid, 1'b0);
      chk("async_rst_data", a_data, 8'h00);
      chk("async_rst_flags", {a_perr, a_ferr, a_ovr, a_busy}, 4'b0000);
      rx_a = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2*CPB) @(posedge clk);
      #1 ready = 1'b1;
      fork
         send_frame(1'b0, 8'h87, 1'b0, 1'b1);
         expect_word(1'b0, 8'h87, 1'b0, 1'b0, 339, "after_rst");
      join

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated show-ahead receive FIFO. It is the next generation of the fixed 8-bit, even-parity, 32-clocks-per-bit receiver that feeds the color-processor command path. It generalises frame format and adds majority-vote sampling, start-bit glitch rejection, per-word error flags, buffering with a valid/ready handshake, and overrun reporting. It sits between the board `Rx` pin and the command decoder / register file.

## Interface
- `CLKS_PER_BIT`, 32: clock cycles per bit; even, ≥ 4.
- `DATA_BITS`, 8: data bits per frame; 5..9, LSB first.
- `PARITY`, 1: 0 = none, 1 = even (XOR of data bits), 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: receive FIFO words; power of 2, ≥ 2.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous, idles high.
- `data_out`  out  DATA_BITS  data field of the FIFO head word.
- `parity_err`  out  1  parity flag of the head word; always 0 when `PARITY`=0.
- `frame_err`  out  1  stop-bit flag of the head word.
- `valid`  out  1  FIFO not empty.
- `ready`  in  1  consumer pops the head word when `valid && ready`.
- `overrun`  out  1  sticky: a frame was dropped because the FIFO was full.
- `busy`  out  1  receiver is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised `rxs`.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- Bit counter runs 0..CLKS_PER_BIT-1. Sample point is counter = CLKS_PER_BIT/2. The bit value is the majority of `rxs` at mid-1, mid and mid+1.
- IDLE -> START on a 1→0 edge of `rxs`. The counter is cleared on the edge cycle.
- START: a majority of 1 at the sample point is a glitch. Return to IDLE with nothing pushed. A majority of 0 goes to DATA.
- DATA: shift in DATA_BITS samples, LSB first. Then go to PARITY, or to STOP when `PARITY`=0.
- PARITY: compare the sample with the computed parity; a mismatch sets the word's `parity_err`.
- STOP: sample STOP_BITS bits. Any 0 sets `frame_err`. At the sample point of the last stop bit, push {frame_err, parity_err, data} into the FIFO.
  - If that stop sample is 1, go to IDLE.
  - If that stop sample is 0 (break or misframe), go to WAIT_HIGH.
- WAIT_HIGH: stay until `rxs`=1, then go to IDLE. Edges seen in WAIT_HIGH are ignored.
- FIFO is show-ahead: the head word drives `data_out`, `parity_err` and `frame_err` whenever `valid`=1. These outputs hold their value while `valid`=0.
- Push while full with no pop in the same cycle: the new word is dropped, `overrun` is set, and stored contents are unchanged.
- Push and pop in the same cycle while full: both are performed and `overrun` is not set.
- `overrun` clears on the first pop after it was set.
- Reset mid-frame: state goes to IDLE, the FIFO empties, and `overrun` clears. The partial frame is discarded.

## Timing
- Reset values:
  - `valid`, `data_out`, `parity_err`, `frame_err`, `overrun`, `busy` = 0.
  - Synchroniser flops = 1.
- `busy` rises one cycle after the synchronised falling edge. It falls on the cycle the state returns to IDLE.
- Let N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS. The push happens at (N-1)·CLKS_PER_BIT + CLKS_PER_BIT/2 + 1 cycles after the synchronised edge. `valid` rises on the following cycle.
- With defaults (N = 11, 10 ns clock), `valid` rises 339 cycles after the `rx` pin falls, including the 2 synchroniser cycles.
- A pop takes effect on the clock edge where `valid && ready`. The next head word, or `valid`=0, appears in the same cycle.
- After the push the receiver is back in IDLE, half a bit before the end of the stop bit, so back-to-back frames are received with no gap.

## Structure
- Shared package / include `uart_defs`:
  - parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - the rx state encoding;
  - a function that computes parity of a DATA_BITS vector for a given mode.
- One sub-module, `sync_fifo`:
  - parameters WIDTH and DEPTH;
  - show-ahead output, full/empty flags, pointer wrap with an extra MSB.
- The receiver FSM, synchroniser and majority voter stay in `uart_rx_fifo`.

## Test plan
- Defaults, send 0x35 with correct even parity, `ready`=1 → `valid` after 339 cycles, `data_out`=0x35, both error flags 0, single-cycle pop.
- Defaults, send 0x4A with the parity bit inverted → `data_out`=0x4A, `parity_err`=1. Repeat with `PARITY`=2, `STOP_BITS`=2 and 0x4A sent with correct odd parity → `parity_err`=0.
- Hold the stop bit of 0x5D low, then keep `rx` low for 3 bit times → one word 0x5D with `frame_err`=1 and no spurious second word. After `rx` returns high, 0x61 is received clean.
- `rx` low pulse of 10 cycles → no push; `busy` pulses and returns to 0 by cycle 18 after the edge.
- `ready`=0, send 0x21, 0x66, 0x7E, 0x87, 0x35 back-to-back → FIFO holds the first four in order and `overrun`=1. Pops yield 0x21, 0x66, 0x7E, 0x87. `overrun` clears on the first pop.
- Assert `rst` low during data bit 3 of a frame → all outputs 0 asynchronously. Release, send 0x87 → received correctly with no residue.
